// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Valid/ready instruction hand-off between the fetch unit
//               (master) and the control unit's fetch stage (slave).
//   instr_out    master -> slave  instruction being offered
//   instr_valid  master -> slave  instr_out holds a valid instruction
//   instr_ready  slave  -> master slave accepts instr_out this cycle
// Revision    : 1.0  initial release
// ============================================================================
interface instruction_fetch_unit_if #(
  parameter int INSTR_W = 8
);
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output instr_out,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Stores a small program loaded byte-by-byte, then on start
//               streams it in order over a valid/ready handshake while
//               tracking the program counter.
// Ports       :
//   clock_pulse  in   single clock, rising edge
//   reset        in   synchronous active-high reset
//   load_strobe  in   append load_data to the program (IDLE only)
//   load_data    in   instruction byte to store
//   start        in   begin (or replay) execution from PC 0
//   fetch        if   master side: instr_out / instr_valid / instr_ready
//   pc_out       out  address of the current or last offered instruction
//   prog_len     out  number of stored instructions, 0..DEPTH
//   done         out  program fully streamed (HALT)
//   load_err     out  sticky illegal-load flag, cleared only by reset
// Build option: define IFETCH_LOOP_EN to replay the program forever instead
//               of stopping in HALT after the last instruction.
// Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  wire                    clock_pulse,
  input  wire                    reset,
  input  wire                    load_strobe,
  input  wire  [INSTR_W-1:0]     load_data,
  input  wire                    start,
  instruction_fetch_unit_if.master fetch,
  output logic [ADDR_W-1:0]      pc_out,
  output logic [ADDR_W:0]        prog_len,
  output logic                   done,
  output logic                   load_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   C_LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   C_LEN_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_PC_ONE   = ADDR_W'(1);

  state_t             state_q,    state_d;
  logic [ADDR_W-1:0]  pc_q,       pc_d;
  logic [ADDR_W:0]    prog_len_q, prog_len_d;
  logic               load_err_q, load_err_d;
  logic [INSTR_W-1:0] instr_q;
  logic               mem_we;
  logic               last_instr;

  // Program storage; deliberately not reset, prog_len gates what is reachable.
  logic [INSTR_W-1:0] mem_q [DEPTH];

  // PC addresses the final stored instruction.
  assign last_instr = ({1'b0, pc_q} == (prog_len_q - C_LEN_ONE));

  // --------------------------------------------------------------------------
  // Next-state / control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_len_d = prog_len_q;
    load_err_d = load_err_q;
    mem_we     = 1'b0;

    // Loads outside IDLE never touch memory, they only flag the error.
    if (load_strobe && (state_q != ST_IDLE)) begin
      load_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A load takes priority over a simultaneous start.
        if (load_strobe) begin
          if (prog_len_q == C_LEN_FULL) begin
            load_err_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + C_LEN_ONE;
          end
        end else if (start && (prog_len_q != '0)) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_PRESENT;
      end

      ST_PRESENT: begin
        if (fetch.instr_ready) begin
          if (last_instr) begin
`ifdef IFETCH_LOOP_EN
            pc_d    = '0;
            state_d = ST_FETCH;
`else
            state_d = ST_HALT;
`endif
          end else begin
            pc_d    = pc_q + C_PC_ONE;
            state_d = ST_FETCH;
          end
        end
      end

      ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_pulse) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      prog_len_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_len_q <= prog_len_d;
      load_err_q <= load_err_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clock_pulse) begin
    if (mem_we) begin
      mem_q[prog_len_q[ADDR_W-1:0]] <= load_data;
    end
  end

  // Synchronous read into the output register; only FETCH updates it, so
  // instr_out stays stable through PRESENT and any stall.
  always_ff @(posedge clock_pulse) begin
    if (reset) begin
      instr_q <= '0;
    end else if (state_q == ST_FETCH) begin
      instr_q <= mem_q[pc_q];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fetch.instr_out   = instr_q;
  assign fetch.instr_valid = (state_q == ST_PRESENT);
  assign pc_out            = pc_q;
  assign prog_len          = prog_len_q;
  assign done              = (state_q == ST_HALT);
  assign load_err          = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_strobe = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       start = 1'b0;
  logic [3:0] pc_out;
  logic [4:0] prog_len;
  logic       done;
  logic       load_err;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_unit_if #(.INSTR_W(8)) fif ();

  instruction_fetch_unit #(
    .DEPTH(16), .ADDR_W(4), .INSTR_W(8)
  ) dut (
    .clock_pulse (clk),
    .reset       (rst),
    .load_strobe (load_strobe),
    .load_data   (load_data),
    .start       (start),
    .fetch       (fif),
    .pc_out      (pc_out),
    .prog_len    (prog_len),
    .done        (done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled and inputs driven 1 ns
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    load_strobe = 1'b0;
    start = 1'b0;
    fif.instr_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    load_strobe = 1'b1;
    load_data   = b;
    tick();
    load_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp++; if (fif.instr_out !== 8'h00) begin n_err++; $display("FAIL reset_instr_out: got %h want 00", fif.instr_out); end
    n_cmp++; if (fif.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", fif.instr_valid); end
    n_cmp++; if (pc_out !== 4'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", pc_out); end
    n_cmp++; if (prog_len !== 5'd0) begin n_err++; $display("FAIL reset_prog_len: got %0d want 0", prog_len); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL reset_load_err: got %b want 0", load_err); end
  endtask

  // Load three bytes, stream them with ready held high, expect HALT.
  task automatic test_load_stream();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h12; exp_b[1] = 8'h37; exp_b[2] = 8'h1C;
    reset_dut();
    load_byte(8'h12);
    n_cmp++; if (prog_len !== 5'd1) begin n_err++; $display("FAIL stream_len1: got %0d want 1", prog_len); end
    load_byte(8'h37);
    load_byte(8'h1C);
    n_cmp++; if (prog_len !== 5'd3) begin n_err++; $display("FAIL stream_len3: got %0d want 3", prog_len); end
    fif.instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (fif.instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_fetch_valid: got %b want 0", fif.instr_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (fif.instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, fif.instr_valid); end
      n_cmp++; if (fif.instr_out !== exp_b[i]) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", i, fif.instr_out, exp_b[i]); end
      n_cmp++; if (pc_out !== 4'(i)) begin n_err++; $display("FAIL stream_pc[%0d]: got %0d want %0d", i, pc_out, i); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stream_done_early[%0d]: got %b want 0", i, done); end
      tick();
      n_cmp++; if (fif.instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_gap_valid[%0d]: got %b want 0", i, fif.instr_valid); end
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stream_done: got %b want 1", done); end
    n_cmp++; if (prog_len !== 5'd3) begin n_err++; $display("FAIL stream_len_end: got %0d want 3", prog_len); end
  endtask

  // From HALT, start replays the same three bytes from PC 0.
  task automatic test_halt_replay();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h12; exp_b[1] = 8'h37; exp_b[2] = 8'h1C;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL replay_done_clr: got %b want 0", done); end
    n_cmp++; if (pc_out !== 4'd0) begin n_err++; $display("FAIL replay_pc0: got %0d want 0", pc_out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (fif.instr_out !== exp_b[i]) begin n_err++; $display("FAIL replay_instr[%0d]: got %h want %h", i, fif.instr_out, exp_b[i]); end
      n_cmp++; if (pc_out !== 4'(i)) begin n_err++; $display("FAIL replay_pc[%0d]: got %0d want %0d", i, pc_out, i); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL replay_done: got %b want 1", done); end
  endtask

  // Stall 5 cycles on PC 1, inject an illegal load, then complete.
  task automatic test_stall();
    reset_dut();
    load_byte(8'h12);
    load_byte(8'h37);
    load_byte(8'h1C);
    fif.instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    fif.instr_ready = 1'b1;
    tick();
    fif.instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (fif.instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, fif.instr_valid); end
      n_cmp++; if (fif.instr_out !== 8'h37) begin n_err++; $display("FAIL stall_instr[%0d]: got %h want 37", i, fif.instr_out); end
      n_cmp++; if (pc_out !== 4'd1) begin n_err++; $display("FAIL stall_pc[%0d]: got %0d want 1", i, pc_out); end
      tick();
    end
    load_strobe = 1'b1;
    load_data = 8'hEE;
    tick();
    load_strobe = 1'b0;
    n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL present_load_err: got %b want 1", load_err); end
    n_cmp++; if (prog_len !== 5'd3) begin n_err++; $display("FAIL present_load_len: got %0d want 3", prog_len); end
    n_cmp++; if (fif.instr_out !== 8'h37) begin n_err++; $display("FAIL present_load_instr: got %h want 37", fif.instr_out); end
    fif.instr_ready = 1'b1;
    tick();
    n_cmp++; if (fif.instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_valid: got %b want 0", fif.instr_valid); end
    n_cmp++; if (pc_out !== 4'd2) begin n_err++; $display("FAIL stall_release_pc: got %0d want 2", pc_out); end
    tick();
    n_cmp++; if (fif.instr_out !== 8'h1C) begin n_err++; $display("FAIL stall_next_instr: got %h want 1C", fif.instr_out); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b want 1", done); end
    fif.instr_ready = 1'b0;
  endtask

  // 17 loads: 16 stored, 17th dropped with load_err; stream to verify all.
  task automatic test_full();
    reset_dut();
    for (int i = 0; i < 16; i++) load_byte(8'hA0 + 8'(i));
    n_cmp++; if (prog_len !== 5'd16) begin n_err++; $display("FAIL full_len16: got %0d want 16", prog_len); end
    n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL full_err_early: got %b want 0", load_err); end
    load_byte(8'h55);
    n_cmp++; if (prog_len !== 5'd16) begin n_err++; $display("FAIL full_len17: got %0d want 16", prog_len); end
    n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL full_err: got %b want 1", load_err); end
    fif.instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++; if (fif.instr_out !== 8'hA0 + 8'(i)) begin n_err++; $display("FAIL full_instr[%0d]: got %h want %h", i, fif.instr_out, 8'hA0 + 8'(i)); end
      n_cmp++; if (pc_out !== 4'(i)) begin n_err++; $display("FAIL full_pc[%0d]: got %0d want %0d", i, pc_out, i); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done: got %b want 1", done); end
    fif.instr_ready = 1'b0;
  endtask

  // start with an empty program is ignored; start+load together: load wins.
  task automatic test_empty_start();
    reset_dut();
    fif.instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (fif.instr_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid0: got %b want 0", fif.instr_valid); end
    tick();
    n_cmp++; if (fif.instr_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid1: got %b want 0", fif.instr_valid); end
    start = 1'b1;
    load_strobe = 1'b1;
    load_data = 8'h99;
    tick();
    start = 1'b0;
    load_strobe = 1'b0;
    n_cmp++; if (prog_len !== 5'd1) begin n_err++; $display("FAIL start_load_len: got %0d want 1", prog_len); end
    tick();
    n_cmp++; if (fif.instr_valid !== 1'b0) begin n_err++; $display("FAIL start_load_ignored: got %b want 0", fif.instr_valid); end
    fif.instr_ready = 1'b0;
  endtask

  // Reset during PRESENT returns everything to reset values.
  task automatic test_reset_mid();
    reset_dut();
    load_byte(8'h12);
    load_byte(8'h37);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (fif.instr_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid: got %b want 1", fif.instr_valid); end
    load_strobe = 1'b1;
    tick();
    load_strobe = 1'b0;
    n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL rmid_pre_err: got %b want 1", load_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (fif.instr_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", fif.instr_valid); end
    n_cmp++; if (fif.instr_out !== 8'h00) begin n_err++; $display("FAIL rmid_instr: got %h want 00", fif.instr_out); end
    n_cmp++; if (pc_out !== 4'd0) begin n_err++; $display("FAIL rmid_pc: got %0d want 0", pc_out); end
    n_cmp++; if (prog_len !== 5'd0) begin n_err++; $display("FAIL rmid_len: got %0d want 0", prog_len); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %b want 0", done); end
    n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL rmid_err: got %b want 0", load_err); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (fif.instr_valid !== 1'b0) begin n_err++; $display("FAIL rmid_start_ignored: got %b want 0", fif.instr_valid); end
  endtask

`ifdef IFETCH_LOOP_EN
  // Two-instruction program loops: PC 0,1,0,1,0,1 and done never rises.
  task automatic test_loop();
    logic [7:0] exp_b [2];
    exp_b[0] = 8'h21; exp_b[1] = 8'h42;
    reset_dut();
    load_byte(8'h21);
    load_byte(8'h42);
    fif.instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (pc_out !== 4'(i % 2)) begin n_err++; $display("FAIL loop_pc[%0d]: got %0d want %0d", i, pc_out, i % 2); end
      n_cmp++; if (fif.instr_out !== exp_b[i % 2]) begin n_err++; $display("FAIL loop_instr[%0d]: got %h want %h", i, fif.instr_out, exp_b[i % 2]); end
      n_cmp++; if (fif.instr_valid !== 1'b1) begin n_err++; $display("FAIL loop_valid[%0d]: got %b want 1", i, fif.instr_valid); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL loop_done[%0d]: got %b want 0", i, done); end
    end
    fif.instr_ready = 1'b0;
  endtask
`endif

  initial begin
    fif.instr_ready = 1'b0;
    test_reset();
`ifdef IFETCH_LOOP_EN
    test_empty_start();
    test_reset_mid();
    test_loop();
`else
    test_load_stream();
    test_halt_replay();
    test_stall();
    test_full();
    test_empty_start();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
